// File: rtl/regfile_pkg.sv
// Shared sizing and types for the 64-bit general-purpose register file.
package regfile_pkg;

  localparam int unsigned REG_DATA_W = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_COUNT  = 2 ** REG_ADDR_W;

  typedef logic [REG_DATA_W-1:0] reg_data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux over the storage array, with
// optional forcing of the hardwired-zero register to 0.
//   mem  : storage array (DEPTH entries of DATA_W)
//   idx  : register index
//   data : mem[idx], or 0 for the hardwired-zero index
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W        = REG_DATA_W,
  parameter int unsigned ADDR_W        = REG_ADDR_W,
  parameter bit          HARDWIRE_ZERO = 1'b0,
  parameter int unsigned ZERO_IDX      = 31
) (
  input  logic [DATA_W-1:0] mem [2**ADDR_W],
  input  logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] data
);

  // Zero register is masked here so its storage contents never matter.
  always_comb begin
    data = mem[idx];
    if (HARDWIRE_ZERO && (idx == ADDR_W'(ZERO_IDX))) begin
      data = '0;
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file.sv
// 32 x 64-bit register file: two combinational read ports, one synchronous
// write port, synchronous active-high reset clearing every register.
//   clk, rst             : clock, synchronous active-high reset
//   regWrite             : write enable
//   writeReg, writeData  : write index and data (applied on rising edge)
//   readReg1, readReg2   : read indices
//   readData1, readData2 : combinational read data (no write bypass)
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W        = REG_DATA_W,
  parameter int unsigned ADDR_W        = REG_ADDR_W,
  parameter bit          HARDWIRE_ZERO = 1'b0,
  parameter int unsigned ZERO_IDX      = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;

  // Writes to the hardwired-zero index are dropped.
  assign wr_en = regWrite &&
                 !(HARDWIRE_ZERO && (writeReg == ADDR_W'(ZERO_IDX)));

  // Storage: reset wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[writeReg] <= writeData;
    end
  end

  regfile_read_port #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .HARDWIRE_ZERO (HARDWIRE_ZERO),
    .ZERO_IDX      (ZERO_IDX)
  ) u_rd1 (
    .mem  (mem),
    .idx  (readReg1),
    .data (readData1)
  );

  regfile_read_port #(
    .DATA_W        (DATA_W),
    .ADDR_W        (ADDR_W),
    .HARDWIRE_ZERO (HARDWIRE_ZERO),
    .ZERO_IDX      (ZERO_IDX)
  ) u_rd2 (
    .mem  (mem),
    .idx  (readReg2),
    .data (readData2)
  );

endmodule : register_file

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read data,
// a negedge monitor pops and compares while a read check is presented.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        regWrite;
  logic [4:0]  readReg1, readReg2, writeReg;
  logic [63:0] writeData;
  logic [63:0] rd1, rd2, zrd1, zrd2;
  logic        chk_valid;

  typedef struct packed {
    logic        zdut;
    logic [63:0] e1;
    logic [63:0] e2;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  localparam logic [63:0] VA = 64'h376235E01BB11AF2;
  localparam logic [63:0] VB = 64'h1BB11AB14DD8AD18;

  always #5 clk = ~clk;

  register_file u_dut (
    .clk(clk), .rst(rst), .regWrite(regWrite),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(rd1), .readData2(rd2),
    .writeReg(writeReg), .writeData(writeData)
  );

  register_file #(.HARDWIRE_ZERO(1'b1), .ZERO_IDX(31)) u_dut_z (
    .clk(clk), .rst(rst), .regWrite(regWrite),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(zrd1), .readData2(zrd2),
    .writeReg(writeReg), .writeData(writeData)
  );

  // Monitor: compare both read ports of the selected DUT mid-cycle.
  always @(negedge clk) begin
    if (chk_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: check presented with no expectation");
      end else begin
        exp_t  e;
        string nm;
        logic [63:0] a1, a2;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a1 = e.zdut ? zrd1 : rd1;
        a2 = e.zdut ? zrd2 : rd2;
        if (a1 !== e.e1 || a2 !== e.e2) begin
          n_bad++;
          $display("FAIL %s: got rd1=%h rd2=%h expected rd1=%h rd2=%h",
                   nm, a1, a2, e.e1, e.e2);
        end
      end
    end
  end

  task automatic check(input string nm, input logic z, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [63:0] e1,
                       input logic [63:0] e2);
    exp_t e;
    readReg1 = r1;
    readReg2 = r2;
    e.zdut = z;
    e.e1 = e1;
    e.e2 = e2;
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  task automatic wr(input logic [4:0] idx, input logic [63:0] d);
    regWrite  = 1'b1;
    writeReg  = idx;
    writeData = d;
    @(posedge clk);
    #1;
    regWrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1; regWrite = 1'b0; readReg1 = '0; readReg2 = '0;
    writeReg = '0; writeData = '0; chk_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset_0",    1'b0, 5'd0,  5'd0,  64'd0, 64'd0);
    check("reset_13",   1'b0, 5'd13, 5'd13, 64'd0, 64'd0);
    check("reset_31",   1'b0, 5'd31, 5'd31, 64'd0, 64'd0);
    check("reset_z",    1'b1, 5'd0,  5'd31, 64'd0, 64'd0);

    wr(5'd13, VA);
    wr(5'd14, VB);
    check("write_13_14", 1'b0, 5'd13, 5'd14, VA, VB);

    regWrite = 1'b0; writeReg = 5'd13; writeData = '1;
    @(posedge clk);
    #1;
    check("write_disable", 1'b0, 5'd13, 5'd13, VA, VA);

    wr(5'd5, 64'hA);
    regWrite = 1'b1; writeReg = 5'd5; writeData = 64'hB;
    check("rdw_before", 1'b0, 5'd5, 5'd13, 64'hA, VA);
    regWrite = 1'b0;
    check("rdw_after",  1'b0, 5'd5, 5'd13, 64'hB, VA);

    check("same_index_14", 1'b0, 5'd14, 5'd14, VB, VB);

    wr(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    check("write_idx0", 1'b0, 5'd0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);

    rst = 1'b1; regWrite = 1'b1; writeReg = 5'd7; writeData = 64'h1234;
    @(posedge clk);
    #1;
    rst = 1'b0; regWrite = 1'b0;
    check("rst_priority_7", 1'b0, 5'd7, 5'd13, 64'd0, 64'd0);
    check("rst_clears_0",   1'b0, 5'd0, 5'd14, 64'd0, 64'd0);

    wr(5'd31, 64'hDEAD);
    wr(5'd30, 64'hDEAD);
    check("hz_31_30",   1'b1, 5'd31, 5'd30, 64'd0, 64'hDEAD);
    check("hz_30_31",   1'b1, 5'd30, 5'd31, 64'hDEAD, 64'd0);
    check("nohz_31_30", 1'b0, 5'd31, 5'd30, 64'hDEAD, 64'hDEAD);

    @(posedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule : tb_register_file
